score_keeper: RTL

Game-score controller in the LCD data domain, clocked by `lcd_clk`. It arbitrates point-add requests from several game sources (alien hits, saucer bonus, etc.) onto a single saturating score register. On game over it sequences the score-versus-high-score comparison and the high-score commit. It then pulses `game_over_finished` to the display path, which consumes `score` and `high_score`.

---
 rtl/score_keeper.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Game-score controller: round-robin point-add arbitration onto a saturating score,
// followed by a fixed-latency high-score compare/commit sequence at game over.
module score_keeper #(
    parameter int N_SRC     = 4,
    parameter int SCORE_W   = 14,
    parameter int PTS_W     = 8,
    parameter int SCORE_MAX = 9999
) (
    input  logic                     lcd_clk,
    input  logic                     rst_n,
    input  logic                     game_start,
    input  logic                     game_over,
    input  logic [N_SRC-1:0]         add_req,
    input  logic [N_SRC*PTS_W-1:0]   add_pts,
    output logic [N_SRC-1:0]         add_ack,
    output logic [SCORE_W-1:0]       score,
    output logic [SCORE_W-1:0]       high_score,
    output logic                     new_record,
    output logic                     game_over_finished,
    output logic                     playing
);

    // state   | meaning
    // IDLE    | between games, score holds last result
    // PLAY    | arbitrating point adds
    // COMPARE | latch score > high_score
    // COMMIT  | update high_score / new_record
    // DONE    | game_over_finished pulse

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_COMPARE,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic               better;

    logic [N_SRC-1:0]   eligible;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTS_W-1:0]   grant_pts;
    logic [SCORE_W:0]   sum_ext;
    logic [SCORE_W-1:0] score_next;
    int                 cand;

    // Scan from highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        eligible  = add_req & ~add_ack;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            cand = int'(rr_ptr) + j;
            if (cand >= N_SRC) begin
                cand = cand - N_SRC;
            end
            cand_idx = PTR_W'(cand);
            if (eligible[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        grant_pts = add_pts[grant_idx*PTS_W +: PTS_W];
        sum_ext   = {1'b0, score} + (SCORE_W+1)'(grant_pts);
        if (sum_ext > (SCORE_W+1)'(SCORE_MAX)) begin
            score_next = SCORE_W'(SCORE_MAX);
        end else begin
            score_next = sum_ext[SCORE_W-1:0];
        end
        if (grant_idx == PTR_W'(N_SRC - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + 1'b1;
        end
    end

    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            rr_ptr             <= '0;
            better             <= 1'b0;
            add_ack            <= '0;
            score              <= '0;
            high_score         <= '0;
            new_record         <= 1'b0;
            game_over_finished <= 1'b0;
            playing            <= 1'b0;
        end else begin
            add_ack            <= '0;
            game_over_finished <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (game_start) begin
                        score      <= '0;
                        new_record <= 1'b0;
                        playing    <= 1'b1;
                        state      <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (game_over) begin
                        playing <= 1'b0;
                        state   <= S_COMPARE;
                    end else if (grant_vld) begin
                        score              <= score_next;
                        add_ack[grant_idx] <= 1'b1;
                        rr_ptr             <= ptr_next;
                    end
                end
                S_COMPARE: begin
                    better <= (score > high_score);
                    state  <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (better) begin
                        high_score <= score;
                        new_record <= 1'b1;
                    end else begin
                        new_record <= 1'b0;
                    end
                    game_over_finished <= 1'b1;
                    state              <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
